// File: rtl/tl_phase_arbiter_if.sv
// Request and lamp bundle between the traffic-light phase arbiter and its environment.
// The master side drives the timebase and requests, and the slave side (the arbiter) drives the lamps.
interface tl_phase_arbiter_if;
    logic       tick;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ns_req, ew_req, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  walk, ped_pending, phase
    );

    modport slave (
        input  tick, ns_req, ew_req, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output walk, ped_pending, phase
    );
endinterface

// File: rtl/tl_phase_arbiter.sv
// Traffic-light phase scheduler: NS/EW green arbitration with yellow and all-red clearance.
// Define TL_PED_PHASE_EN to build the optional pedestrian walk phase.
module tl_phase_arbiter #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 6,
    parameter int CW        = 8
) (
    input  logic                clk,
    input  logic                rst,
    tl_phase_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED_B = 3'd5
`ifdef TL_PED_PHASE_EN
        , PED = 3'd6
`endif
    } state_e;

    typedef struct packed {
        logic ns_r;
        logic ns_y;
        logic ns_g;
        logic ew_r;
        logic ew_y;
        logic ew_g;
        logic walk;
    } lamps_t;

    localparam logic [CW-1:0] MIN_M1 = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_M1 = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_M1 = CW'(YELLOW - 1);
    localparam logic [CW-1:0] RED_M1 = CW'(ALL_RED - 1);
`ifdef TL_PED_PHASE_EN
    localparam logic [CW-1:0] WALK_M1 = CW'(WALK - 1);
`endif
    localparam lamps_t LAMPS_RST = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ns_pend_q, ns_pend_d;
    logic           ew_pend_q, ew_pend_d;
    lamps_t         lamps_q, lamps_d;
    logic           ns_set, ew_set, ped_set;
    logic           changing;

`ifdef TL_PED_PHASE_EN
    logic           ped_q, ped_d;
    logic           last_ew_q, last_ew_d;
`else
    logic           unused_ped;
    assign unused_ped = bus.ped_req;
`endif

    // Demand as it will stand after this edge, so a request arriving with the deciding tick still counts.
    always_comb begin
        ns_set = ns_pend_q | bus.ns_req;
        ew_set = ew_pend_q | bus.ew_req;
`ifdef TL_PED_PHASE_EN
        ped_set = ped_q | bus.ped_req;
`else
        ped_set = 1'b0;
`endif
    end

    // Next-state logic; every transition is gated by the timebase tick.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        if (bus.tick) begin
            case (state_q)
                NS_G: if ((ew_set | ped_set) && cnt_q >= MIN_M1 &&
                          (!bus.ns_req || cnt_q >= MAX_M1)) state_d = NS_Y;
                NS_Y: if (cnt_q == YEL_M1) state_d = RED_A;
                RED_A: if (cnt_q == RED_M1) begin
`ifdef TL_PED_PHASE_EN
                    state_d = ped_set ? PED : EW_G;
`else
                    state_d = EW_G;
`endif
                end
                EW_G: if ((ns_set | ped_set) && cnt_q >= MIN_M1 &&
                          (!bus.ew_req || cnt_q >= MAX_M1)) state_d = EW_Y;
                EW_Y: if (cnt_q == YEL_M1) state_d = RED_B;
                RED_B: if (cnt_q == RED_M1) begin
`ifdef TL_PED_PHASE_EN
                    state_d = ped_set ? PED : NS_G;
`else
                    state_d = NS_G;
`endif
                end
`ifdef TL_PED_PHASE_EN
                PED: if (cnt_q == WALK_M1) state_d = last_ew_q ? NS_G : EW_G;
`endif
                default: state_d = RED_B;
            endcase
        end
    end

    // Phase counter and demand latches; clearing on entry overrides a same-cycle request.
    always_comb begin
        changing  = (state_d != state_q);
        cnt_d     = cnt_q;
        if (changing)                      cnt_d = '0;
        else if (bus.tick && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
        ns_pend_d = (changing && state_d == NS_G) ? 1'b0 : ns_set;
        ew_pend_d = (changing && state_d == EW_G) ? 1'b0 : ew_set;
`ifdef TL_PED_PHASE_EN
        ped_d     = (changing && state_d == PED) ? 1'b0 : ped_set;
        last_ew_d = last_ew_q;
        if (changing && state_d == EW_G) last_ew_d = 1'b1;
        if (changing && state_d == NS_G) last_ew_d = 1'b0;
`endif
    end

    // Lamp decode from the next state so registered lamps switch on the deciding edge.
    always_comb begin
        lamps_d = LAMPS_RST;
        case (state_d)
            NS_G: begin lamps_d.ns_r = 1'b0; lamps_d.ns_g = 1'b1; end
            NS_Y: begin lamps_d.ns_r = 1'b0; lamps_d.ns_y = 1'b1; end
            EW_G: begin lamps_d.ew_r = 1'b0; lamps_d.ew_g = 1'b1; end
            EW_Y: begin lamps_d.ew_r = 1'b0; lamps_d.ew_y = 1'b1; end
`ifdef TL_PED_PHASE_EN
            PED:  lamps_d.walk = 1'b1;
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RED_B;
            cnt_q     <= '0;
            ns_pend_q <= 1'b0;
            ew_pend_q <= 1'b0;
            lamps_q   <= LAMPS_RST;
`ifdef TL_PED_PHASE_EN
            ped_q     <= 1'b0;
            last_ew_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ns_pend_q <= ns_pend_d;
            ew_pend_q <= ew_pend_d;
            lamps_q   <= lamps_d;
`ifdef TL_PED_PHASE_EN
            ped_q     <= ped_d;
            last_ew_q <= last_ew_d;
`endif
        end
    end

    assign bus.ns_red    = lamps_q.ns_r;
    assign bus.ns_yellow = lamps_q.ns_y;
    assign bus.ns_green  = lamps_q.ns_g;
    assign bus.ew_red    = lamps_q.ew_r;
    assign bus.ew_yellow = lamps_q.ew_y;
    assign bus.ew_green  = lamps_q.ew_g;
    assign bus.walk      = lamps_q.walk;
    assign bus.phase     = state_q;
`ifdef TL_PED_PHASE_EN
    assign bus.ped_pending = ped_q;
`else
    assign bus.ped_pending = 1'b0;
`endif

endmodule

// File: tb/tb_tl_phase_arbiter.sv
// Self-checking bench for tl_phase_arbiter: directed phase scenarios plus randomized traffic
// compared against a tick-counting behavioural model of the phase rules.
module tb_tl_phase_arbiter;

    localparam int MIN_GREEN = 8;
    localparam int MAX_GREEN = 20;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;
    localparam int WALK      = 6;
    localparam int CNT_MAX   = 255;
`ifdef TL_PED_PHASE_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif
    localparam logic [10:0] RESET_VEC = {3'd5, 6'b100100, 2'b00};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tl_phase_arbiter_if bus ();

    tl_phase_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: current phase number, ticks already spent in it, outstanding demand.
    int m_phase;
    int m_ticks;
    bit m_ns, m_ew, m_ped, m_last_ew;

    task automatic model_reset();
        m_phase = 5; m_ticks = 0;
        m_ns = 0; m_ew = 0; m_ped = 0; m_last_ew = 1;
    endtask

    task automatic model_step(input bit t, input bit ns, input bit ew, input bit ped);
        bit ns_d, ew_d, ped_d, mine, other;
        int nxt;
        ns_d  = m_ns | ns;
        ew_d  = m_ew | ew;
        ped_d = PED_EN && (m_ped | ped);
        nxt   = m_phase;
        if (t) begin
            if (m_phase == 0 || m_phase == 3) begin
                mine  = (m_phase == 0) ? ns : ew;
                other = (m_phase == 0) ? ew_d : ns_d;
                if ((other || ped_d) && m_ticks + 1 >= MIN_GREEN &&
                    (!mine || m_ticks + 1 >= MAX_GREEN)) nxt = m_phase + 1;
            end else if (m_phase == 1 || m_phase == 4) begin
                if (m_ticks + 1 == YELLOW) nxt = m_phase + 1;
            end else if (m_phase == 2 || m_phase == 5) begin
                if (m_ticks + 1 == ALL_RED) nxt = ped_d ? 6 : ((m_phase == 2) ? 3 : 0);
            end else if (m_phase == 6) begin
                if (m_ticks + 1 == WALK) nxt = m_last_ew ? 0 : 3;
            end
        end
        if (nxt != m_phase)             m_ticks = 0;
        else if (t && m_ticks < CNT_MAX) m_ticks++;
        m_ns  = (nxt == 0 && m_phase != 0) ? 1'b0 : ns_d;
        m_ew  = (nxt == 3 && m_phase != 3) ? 1'b0 : ew_d;
        m_ped = (nxt == 6 && m_phase != 6) ? 1'b0 : ped_d;
        if (nxt == 3 && m_phase != 3) m_last_ew = 1;
        if (nxt == 0 && m_phase != 0) m_last_ew = 0;
        m_phase = nxt;
    endtask

    function automatic logic [10:0] obs_vec();
        return {bus.phase, bus.ns_red, bus.ns_yellow, bus.ns_green,
                bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk, bus.ped_pending};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [2:0] ph;
        ph = m_phase[2:0];
        return {ph, !(ph == 3'd0 || ph == 3'd1), ph == 3'd1, ph == 3'd0,
                !(ph == 3'd3 || ph == 3'd4), ph == 3'd4, ph == 3'd3, ph == 3'd6, m_ped};
    endfunction

    // Inputs are applied just after an edge, then the model follows the DUT across the next edge.
    task automatic drive_cycle(input bit t, input bit ns, input bit ew, input bit ped);
        bus.tick = t; bus.ns_req = ns; bus.ew_req = ew; bus.ped_req = ped;
        @(posedge clk);
        model_step(t, ns, ew, ped);
        #1;
    endtask

    task automatic do_reset();
        bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_until(input logic [2:0] target, input bit ns, input bit ew, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            drive_cycle(1'b1, ns, ew, 1'b0);
            ok = (bus.phase == target);
        end
    endtask

    task automatic test_reset();
        bus.tick = 0; bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
        rst = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_state: got %b want %b", obs_vec(), RESET_VEC);
        end
        @(posedge clk); #1 rst = 1'b1;
        drive_cycle(1'b0, 0, 0, 0);
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_no_tick: got %b want %b", obs_vec(), RESET_VEC);
        end
        drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (bus.phase !== 3'd0 || bus.ns_green !== 1'b1 || bus.ew_red !== 1'b1) begin
            errors++; $display("FAIL reset_first_tick: phase %0d ns_g %b ew_r %b want 0 1 1",
                               bus.phase, bus.ns_green, bus.ew_red);
        end
        for (int k = 0; k < 30; k++) begin
            drive_cycle(1'b1, 0, 0, 0);
            checks++;
            if (bus.phase !== 3'd0) begin
                errors++; $display("FAIL idle_rest k=%0d: phase %0d want 0", k, bus.phase);
            end
        end
    endtask

    task automatic test_min_green();
        logic [2:0] want;
        do_reset();
        drive_cycle(1'b1, 0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            drive_cycle(1'b1, 1'b0, k == 2, 1'b0);
            want = (k < 7) ? 3'd0 : (k < 10) ? 3'd1 : (k < 11) ? 3'd2 : 3'd3;
            checks++;
            if (bus.phase !== want) begin
                errors++; $display("FAIL min_green k=%0d: phase %0d want %0d", k, bus.phase, want);
            end
        end
        checks++;
        if (bus.ew_green !== 1'b1 || bus.ns_red !== 1'b1) begin
            errors++; $display("FAIL min_green_lamps: ew_g %b ns_r %b want 1 1", bus.ew_green, bus.ns_red);
        end
    endtask

    task automatic test_max_green();
        logic [2:0] want;
        do_reset();
        drive_cycle(1'b1, 0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            drive_cycle(1'b1, 1'b1, k == 0, 1'b0);
            want = (k < 19) ? 3'd0 : 3'd1;
            checks++;
            if (bus.phase !== want) begin
                errors++; $display("FAIL max_green k=%0d: phase %0d want %0d", k, bus.phase, want);
            end
        end
        checks++;
        if (bus.ns_yellow !== 1'b1 || bus.ns_green !== 1'b0) begin
            errors++; $display("FAIL max_green_lamps: ns_y %b ns_g %b want 1 0", bus.ns_yellow, bus.ns_green);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        drive_cycle(1'b1, 0, 0, 0);
        run_until(3'd3, 1'b0, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_reach_ew_g: phase %0d want 3", bus.phase); end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(3'd4, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_reach_ew_y: phase %0d want 4", bus.phase); end
        drive_cycle(1'b1, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL rst_mid_async: got %b want %b", obs_vec(), RESET_VEC);
        end
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        drive_cycle(1'b0, 0, 0, 0);
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL rst_mid_hold: got %b want %b", obs_vec(), RESET_VEC);
        end
        drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++; $display("FAIL rst_mid_restart: phase %0d want 0", bus.phase);
        end
    endtask

    task automatic test_random();
        bit t, ns, ew, ped;
        do_reset();
        ns = 0; ew = 0;
        for (int c = 0; c < 3000; c++) begin
            t   = (c >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ns = ~ns;
            if ($urandom_range(0, 9) == 0) ew = ~ew;
            ped = ($urandom_range(0, 39) == 0);
            drive_cycle(t, ns, ew, ped);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d: got %b want %b", c, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef TL_PED_PHASE_EN
    task automatic test_ped_walk();
        bit ok;
        int walk_cycles;
        do_reset();
        drive_cycle(1'b1, 0, 0, 0);
        drive_cycle(1'b1, 0, 1, 0);
        run_until(3'd3, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ped_reach_ew_g: phase %0d want 3", bus.phase); end
        drive_cycle(1'b1, 0, 0, 1);
        checks++;
        if (bus.ped_pending !== 1'b1) begin
            errors++; $display("FAIL ped_latch: ped_pending %b want 1", bus.ped_pending);
        end
        run_until(3'd6, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || bus.walk !== 1'b1 || bus.ped_pending !== 1'b0 || bus.ns_red !== 1'b1 || bus.ew_red !== 1'b1) begin
            errors++; $display("FAIL ped_entry: phase %0d walk %b pend %b want 6 1 0", bus.phase, bus.walk, bus.ped_pending);
        end
        walk_cycles = 0;
        for (int i = 0; i < 20 && bus.phase == 3'd6; i++) begin
            drive_cycle(1'b1, 0, 0, 0);
            walk_cycles++;
        end
        checks++;
        if (walk_cycles != WALK || bus.phase !== 3'd0 || bus.walk !== 1'b0) begin
            errors++; $display("FAIL ped_walk_len: ticks %0d phase %0d want %0d then 0", walk_cycles, bus.phase, WALK);
        end
    endtask

    task automatic test_ped_simul();
        bit ok;
        do_reset();
        drive_cycle(1'b1, 0, 0, 0);
        drive_cycle(1'b1, 0, 0, 1);
        run_until(3'd1, 1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL simul_reach_ns_y: phase %0d want 1", bus.phase); end
        drive_cycle(1'b1, 0, 0, 0);
        drive_cycle(1'b1, 0, 0, 0);
        drive_cycle(1'b1, 0, 1, 1);
        checks++;
        if (bus.phase !== 3'd2) begin errors++; $display("FAIL simul_red_a: phase %0d want 2", bus.phase); end
        drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (bus.phase !== 3'd6) begin errors++; $display("FAIL simul_ped_first: phase %0d want 6", bus.phase); end
        for (int i = 0; i < WALK - 1; i++) drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (dut.ew_pend_q !== 1'b1 || bus.phase !== 3'd6) begin
            errors++; $display("FAIL simul_ew_pend_kept: ew_pend %b phase %0d want 1 6", dut.ew_pend_q, bus.phase);
        end
        drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (bus.phase !== 3'd3) begin errors++; $display("FAIL simul_then_ew_g: phase %0d want 3", bus.phase); end
    endtask
`endif

    initial begin
        test_reset();
        test_min_green();
        test_max_green();
        test_reset_mid();
`ifdef TL_PED_PHASE_EN
        test_ped_walk();
        test_ped_simul();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_phase_arbiter.md
# tl_phase_arbiter

Phase scheduler for the traffic-light controller. It arbitrates green time between the north-south and east-west approaches and an optional pedestrian walk phase. It enforces minimum green, maximum green, yellow and all-red clearance intervals, and drives the six lamp outputs plus the walk lamp. Timing advances on a one-cycle `tick` enable from the system prescaler, and request inputs come from the debounce stage.

## Interface
- `MIN_GREEN`, 8: minimum green duration, ticks (≥1)
- `MAX_GREEN`, 20: maximum green duration under conflicting demand, ticks (≥ MIN_GREEN)
- `YELLOW`, 3: yellow duration, ticks (≥1)
- `ALL_RED`, 1: all-red clearance duration, ticks (≥1)
- `WALK`, 6: pedestrian walk duration, ticks (≥1)
- `CW`, 8: phase counter width; every duration must be < 2^CW
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `tick` in 1: timebase enable, one cycle wide
- `ns_req` in 1: NS vehicle-presence level
- `ew_req` in 1: EW vehicle-presence level
- `ped_req` in 1: pedestrian button pulse (debounced)
- `ns_red`, `ns_yellow`, `ns_green` out 1 each: NS lamps
- `ew_red`, `ew_yellow`, `ew_green` out 1 each: EW lamps
- `walk` out 1: pedestrian walk lamp
- `ped_pending` out 1: latched pedestrian request
- `phase` out 3: current state encoding

## Operation
- States and encodings:
  - NS_G=0
  - NS_Y=1
  - RED_A=2 (after NS)
  - EW_G=3
  - EW_Y=4
  - RED_B=5 (after EW)
  - PED=6
- Lamps are decoded from the state only.
  - In RED_A, RED_B and PED, both approaches show red.
  - `walk` is 1 only in PED.
- Phase counter `cnt` behaviour:
  - Cleared on every state change.
  - Increments on `tick` and saturates at 2^CW−1.
  - All transitions happen only in cycles with `tick`=1. Evaluation uses the pre-increment `cnt`.
- Demand latches `ns_pend`, `ew_pend`, `ped_pending`:
  - `ns_pend` and `ew_pend` are set while the corresponding `*_req`=1. `ped_pending` is set on `ped_req`=1.
  - `ns_pend` is cleared on entry to NS_G, `ew_pend` on entry to EW_G, and `ped_pending` on entry to PED.
  - A request asserted in the entry cycle is absorbed (the clear wins).
- Green exit, NS_G → NS_Y (EW_G symmetric):
  - Conflict = `ew_pend` | `ped_pending`.
  - Exit when conflict=1, `cnt` ≥ MIN_GREEN−1, and either `ns_req`=0 or `cnt` ≥ MAX_GREEN−1.
  - With no conflict, green rests indefinitely.
- Timed exits, each taken when `cnt` = duration−1:
  - NS_Y → RED_A and EW_Y → RED_B at YELLOW−1.
  - RED_A and RED_B exit at ALL_RED−1.
- After RED_A: go to PED if `ped_pending`, else EW_G.
- After RED_B: go to PED if `ped_pending`, else NS_G.
- PED exits at WALK−1 to the green opposite the last green. A 1-bit `last_ew` register, set on entry to EW_G and cleared on entry to NS_G, selects it.
- Reset state and values:
  - RED_B, `cnt`=0, all latches 0, `last_ew`=1.
  - Outputs: `ns_red`=`ew_red`=1, all other lamps 0, `walk`=0, `ped_pending`=0, `phase`=5.

## Timing
- State, counter, latches and outputs are all registered. Lamp outputs change on the clock edge that samples the deciding `tick`, so they are visible the next cycle.
- A request latches on the edge where it is sampled. A request and a deciding tick in the same cycle are both honoured: the latch input feeds the transition decision combinationally.
- Fixed phases last exactly duration×tick-period. Green lasts at least MIN_GREEN ticks and at most MAX_GREEN ticks once conflict exists, unless conflict arrives after MAX_GREEN−1.
- Reset assertion mid-phase returns to the reset state immediately and asynchronously. The first transition happens ALL_RED ticks after release.
- `tick` held continuously high is legal: durations become clock cycles.

## Configuration
- `TL_PED_PHASE_EN` defined: the pedestrian phase is built as described.
- Undefined:
  - `ped_req` is ignored, and `ped_pending` and `walk` are tied to 0.
  - The PED state and `last_ew` are removed.
  - Conflict is the opposing vehicle latch only.

## Test plan
- Reset release with no requests, `tick` every cycle → `phase` 5→0 after 1 tick. NS_G then holds indefinitely.
- In NS_G, `ew_req` pulsed at tick 2 with `ns_req`=0 → NS_Y entered after tick 7 (MIN), RED_A 3 ticks later, EW_G 1 tick after that.
- In NS_G, `ns_req` held high, `ew_req` at tick 0 → NS_G persists until tick 19, then NS_Y (MAX=20).
- `TL_PED_PHASE_EN`, `ped_req` pulse during EW_G → EW_Y → RED_B → PED. `walk`=1 for 6 ticks, `ped_pending` clears on PED entry, next state NS_G.
- Simultaneous `ew_req` on the NS_Y→RED_A tick, plus `ped_req` → PED precedes EW_G, and `ew_pend` is still 1 after PED.
- `rst` low for 1 cycle in the middle of EW_Y → all-red immediately and `phase`=5. The normal sequence restarts after release.
